// File: rtl/seq_detector_param_if.sv
// -----------------------------------------------------------------------------
// seq_detector_param_if
// Bundles the serial input, configuration and result signals of
// seq_detector_param. clk and reset stay plain ports on the module.
//   master : drives input_valid, input_bit, overlap, cfg_load, cfg_pattern,
//            cfg_len, cnt_clr; observes detected, detected_q, det_count, cfg_err
//   slave  : the detector side (mirror of master)
// -----------------------------------------------------------------------------
interface seq_detector_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             input_valid;
  logic             input_bit;
  logic             overlap;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cnt_clr;
  logic             detected;
  logic             detected_q;
  logic [CNT_W-1:0] det_count;
  logic             cfg_err;

  modport master (
    output input_valid, input_bit, overlap, cfg_load, cfg_pattern, cfg_len, cnt_clr,
    input  detected, detected_q, det_count, cfg_err
  );

  modport slave (
    input  input_valid, input_bit, overlap, cfg_load, cfg_pattern, cfg_len, cnt_clr,
    output detected, detected_q, det_count, cfg_err
  );
endinterface

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Run-time configurable serial pattern detector (Mealy). Bits shift into a
// history register; a match is flagged in the same cycle the final pattern
// bit is presented. Supports overlapping / non-overlapping detection, a
// saturating match counter and validated pattern reconfiguration.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : seq_detector_param_if.slave (data, config, results)
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_1011),
  parameter int               RST_LEN = 4,
  parameter int               CNT_W   = 16
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int               LEN_W    = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] ONE      = PAT_W'(1);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             r_det_q;
  logic             r_cfg_err;

  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic             w_fill_ok;
  logic             w_match;
  logic             w_det;
  logic             w_cfg_ok;

  // NOTE: every signal written here is assigned on every path, so no latch
  // can be inferred; keep it that way when editing.
  always_comb begin
    // Candidate window: the L-1 most recent bits plus the bit on the wire.
    w_window  = {r_hist[PAT_W-2:0], bus.input_bit};
    // Low L bits set; for L = PAT_W the shift wraps to 0 and the subtraction
    // yields all ones, which is exactly the full-width mask.
    w_mask    = (ONE << r_len) - ONE;
    // fill >= L-1 rewritten as fill+1 >= L to avoid underflow.
    w_fill_ok = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len};
    w_match   = ((w_window ^ r_pat) & w_mask) == '0;
    w_det     = bus.input_valid & ~bus.cfg_load & ~reset & w_fill_ok & w_match;
    w_cfg_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= FILL_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= RST_PAT;
      r_len     <= LEN_W'(RST_LEN);
      r_cnt     <= '0;
      r_det_q   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_det_q   <= w_det;
      r_cfg_err <= 1'b0;

      if (bus.cfg_load) begin
        // Any simultaneous input bit is dropped; the pattern restarts empty.
        r_fill <= '0;
        if (w_cfg_ok) begin
          r_pat <= bus.cfg_pattern;
          r_len <= bus.cfg_len;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (bus.input_valid) begin
        r_hist <= {r_hist[PAT_W-2:0], bus.input_bit};
        if (w_det && !bus.overlap) begin
          r_fill <= '0;
        end else if (r_fill != FILL_MAX) begin
          r_fill <= r_fill + LEN_W'(1);
        end
      end

      // A clear coinciding with a match still counts that match.
      if (bus.cnt_clr) begin
        r_cnt <= w_det ? CNT_W'(1) : '0;
      end else if (w_det && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.detected   = w_det;
  assign bus.detected_q = r_det_q;
  assign bus.det_count  = r_cnt;
  assign bus.cfg_err    = r_cfg_err;
endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
// Directed bench for seq_detector_param. Inputs change on the falling edge;
// detected is sampled 1 time unit later, registered outputs are sampled at
// the following falling edge.
// Two instances: default (CNT_W=16) and a 2-bit counter for saturation.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  seq_detector_param_if #(.PAT_W(8), .CNT_W(16)) bus  ();
  seq_detector_param_if #(.PAT_W(8), .CNT_W(2))  bus2 ();

  seq_detector_param #(.PAT_W(8), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  seq_detector_param #(.PAT_W(8), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    bus.input_valid  = 1'b0;
    bus.input_bit    = 1'b0;
    bus.overlap      = 1'b1;
    bus.cfg_load     = 1'b0;
    bus.cfg_pattern  = '0;
    bus.cfg_len      = '0;
    bus.cnt_clr      = 1'b0;
    bus2.input_valid = 1'b0;
    bus2.input_bit   = 1'b0;
    bus2.overlap     = 1'b1;
    bus2.cfg_load    = 1'b0;
    bus2.cfg_pattern = '0;
    bus2.cfg_len     = '0;
    bus2.cnt_clr     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle on the default instance: q_prev is detected_q before the new
  // inputs are applied (i.e. the previous cycle's registered result).
  task automatic send(input logic v, input logic b, output logic d, output logic q_prev);
    @(negedge clk);
    q_prev          = bus.detected_q;
    bus.input_valid = v;
    bus.input_bit   = b;
    #1 d = bus.detected;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    // Drive activity that must be ignored while reset is held.
    bus.input_valid = 1'b1;
    bus.input_bit   = 1'b1;
    bus.cnt_clr     = 1'b0;
    #1;
    n_checks++;
    if (bus.detected !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_detected: got %b expected 0", bus.detected);
    end
    @(negedge clk);
    n_checks++;
    if (bus.det_count !== 16'd0) begin
      n_errors++;
      $display("FAIL reset_det_count: got %0d expected 0", bus.det_count);
    end
    n_checks++;
    if (bus.detected_q !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_detected_q: got %b expected 0", bus.detected_q);
    end
    n_checks++;
    if (bus.cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cfg_err: got %b expected 0", bus.cfg_err);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_stream_overlap(input logic ov, input logic [6:0] exp_det, input int exp_cnt);
    logic [6:0] bits;
    logic d, q, prev;
    bits = 7'b1011011;
    do_reset();
    bus.overlap = ov;
    prev = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(1'b1, bits[6-i], d, q);
      n_checks++;
      if (d !== exp_det[6-i]) begin
        n_errors++;
        $display("FAIL stream_ov%0b_det bit%0d: got %b expected %b", ov, i + 1, d, exp_det[6-i]);
      end
      if (i > 0) begin
        n_checks++;
        if (q !== prev) begin
          n_errors++;
          $display("FAIL stream_ov%0b_det_q bit%0d: got %b expected %b", ov, i, q, prev);
        end
      end
      prev = exp_det[6-i];
    end
    send(1'b0, 1'b1, d, q);
    n_checks++;
    if (q !== prev) begin
      n_errors++;
      $display("FAIL stream_ov%0b_det_q last: got %b expected %b", ov, q, prev);
    end
    n_checks++;
    if (d !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_ov%0b_idle_det: got %b expected 0", ov, d);
    end
    n_checks++;
    if (bus.det_count !== 16'(exp_cnt)) begin
      n_errors++;
      $display("FAIL stream_ov%0b_count: got %0d expected %0d", ov, bus.det_count, exp_cnt);
    end
  endtask

  task automatic test_cfg_load();
    logic [7:0] bits;
    logic d, q;
    bits = 8'b1100_0011;
    do_reset();
    // Valid config, with a simultaneous input bit that must be discarded.
    @(negedge clk);
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 8'b1100_0011;
    bus.cfg_len     = 4'd8;
    bus.input_valid = 1'b1;
    bus.input_bit   = 1'b1;
    #1;
    n_checks++;
    if (bus.detected !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_load_det: got %b expected 0", bus.detected);
    end
    @(negedge clk);
    bus.cfg_load    = 1'b0;
    bus.input_valid = 1'b0;
    n_checks++;
    if (bus.cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_ok_err: got %b expected 0", bus.cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      send(1'b1, bits[7-i], d, q);
      n_checks++;
      if (d !== (i == 7)) begin
        n_errors++;
        $display("FAIL cfg8_det bit%0d: got %b expected %b", i + 1, d, (i == 7));
      end
    end
    // Rejected config (len 9) with a pattern that would never match.
    @(negedge clk);
    bus.input_valid = 1'b0;
    bus.cfg_load    = 1'b1;
    bus.cfg_pattern = 8'h00;
    bus.cfg_len     = 4'd9;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    n_checks++;
    if (bus.cfg_err !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg_len9_err: got %b expected 1", bus.cfg_err);
    end
    @(negedge clk);
    n_checks++;
    if (bus.cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL cfg_err_pulse_width: got %b expected 0", bus.cfg_err);
    end
    // Rejected config (len 0) also pulses.
    bus.cfg_load = 1'b1;
    bus.cfg_len  = 4'd0;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    n_checks++;
    if (bus.cfg_err !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg_len0_err: got %b expected 1", bus.cfg_err);
    end
    // The 8-bit configuration must still be in force.
    for (int i = 0; i < 8; i++) begin
      send(1'b1, bits[7-i], d, q);
      n_checks++;
      if (d !== (i == 7)) begin
        n_errors++;
        $display("FAIL cfg_retained_det bit%0d: got %b expected %b", i + 1, d, (i == 7));
      end
    end
    send(1'b0, 1'b0, d, q);
    n_checks++;
    if (bus.det_count !== 16'd2) begin
      n_errors++;
      $display("FAIL cfg_count: got %0d expected 2", bus.det_count);
    end
  endtask

  task automatic test_reset_mid_match();
    logic d, q;
    do_reset();
    send(1'b1, 1'b1, d, q);
    send(1'b1, 1'b0, d, q);
    send(1'b1, 1'b1, d, q);
    // Reset cycle presenting the completing bit: must not detect.
    @(negedge clk);
    reset           = 1'b1;
    bus.input_valid = 1'b1;
    bus.input_bit   = 1'b1;
    #1;
    n_checks++;
    if (bus.detected !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_during: got %b expected 0", bus.detected);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.detected !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_after: got %b expected 0", bus.detected);
    end
    send(1'b0, 1'b0, d, q);
    n_checks++;
    if (bus.det_count !== 16'd0) begin
      n_errors++;
      $display("FAIL midreset_count: got %0d expected 0", bus.det_count);
    end
  endtask

  task automatic test_valid_gaps();
    logic [7:0] v, b;
    logic d, q;
    // Index 0 is the MSB; invalid slots carry 1s that would complete the
    // pattern if they were sampled.
    v = 8'b1010_0101;
    b = 8'b1101_1111;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(v[7-i], b[7-i], d, q);
      n_checks++;
      if (d !== (i == 7)) begin
        n_errors++;
        $display("FAIL gaps_det cycle%0d: got %b expected %b", i, d, (i == 7));
      end
    end
    send(1'b0, 1'b0, d, q);
    n_checks++;
    if (bus.det_count !== 16'd1) begin
      n_errors++;
      $display("FAIL gaps_count: got %0d expected 1", bus.det_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    // Length 1, bit0 = 1; upper pattern bits are deliberately noisy.
    @(negedge clk);
    bus2.cfg_load    = 1'b1;
    bus2.cfg_pattern = 8'b1010_0101;
    bus2.cfg_len     = 4'd1;
    @(negedge clk);
    bus2.cfg_load    = 1'b0;
    bus2.input_valid = 1'b1;
    bus2.input_bit   = 1'b1;
    #1;
    n_checks++;
    if (bus2.detected !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_len1_det: got %b expected 1", bus2.detected);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus2.det_count !== 2'((k < 3) ? k : 3)) begin
        n_errors++;
        $display("FAIL sat_count step%0d: got %0d expected %0d", k, bus2.det_count, (k < 3) ? k : 3);
      end
    end
    bus2.cnt_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus2.det_count !== 2'd1) begin
      n_errors++;
      $display("FAIL sat_clr_with_match: got %0d expected 1", bus2.det_count);
    end
    bus2.input_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus2.det_count !== 2'd0) begin
      n_errors++;
      $display("FAIL sat_clr_alone: got %0d expected 0", bus2.det_count);
    end
    bus2.cnt_clr     = 1'b0;
    bus2.input_valid = 1'b1;
    bus2.input_bit   = 1'b0;
    #1;
    n_checks++;
    if (bus2.detected !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_len1_zero: got %b expected 0", bus2.detected);
    end
    bus2.input_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_stream_overlap(1'b1, 7'b0001001, 2);
    test_stream_overlap(1'b0, 7'b0001000, 1);
    test_cfg_load();
    test_reset_mid_match();
    test_valid_gaps();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits (2..32).
REQ-002 Parameter RST_PAT, default 8'b0000_1011: pattern loaded at reset, LSB-aligned.
REQ-003 Parameter RST_LEN, default 4: pattern length loaded at reset (1..PAT_W).
REQ-004 Parameter CNT_W, default 16: width of detection counter.
REQ-005 Derived LEN_W = $clog2(PAT_W+1).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 input_valid  input  1  input_bit is sampled this cycle when high.
REQ-009 input_bit  input  1  serial data bit.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid cycle.
REQ-011 cfg_load  input  1  one-cycle strobe that updates pattern/length.
REQ-012 cfg_pattern  input  PAT_W  new pattern, LSB-aligned.
REQ-013 cfg_len  input  LEN_W  new pattern length.
REQ-014 cnt_clr  input  1  clears det_count.
REQ-015 detected  output  1  Mealy match flag, combinational from the current input and state.
REQ-016 detected_q  output  1  detected registered one cycle later.
REQ-017 det_count  output  CNT_W  saturating count of matches.
REQ-018 cfg_err  output  1  registered one-cycle pulse on a rejected cfg_load.

Function
REQ-019 Bit order: for length L, the first-received bit is compared with pattern[L-1] and the last with pattern[0]; e.g. 1011 is pattern 4'b1011 with L=4.
REQ-020 State: history shift register (PAT_W bits, new bit enters LSB), fill counter (0..PAT_W, saturating), pattern register, length register.
REQ-021 On a valid cycle, history shifts left by one, input_bit enters the LSB, and fill increments (saturating at PAT_W).
REQ-022 detected = input_valid & !cfg_load & (fill >= L-1) & ({history[L-2:0], input_bit} == pattern[L-1:0]); for L=1, compare input_bit only.
REQ-023 Latency: detected asserts in the same cycle the final pattern bit is presented, with zero cycles of delay; detected_q follows one cycle later.
REQ-024 Overlap mode: history and fill update normally after a match, so 1011011 with pattern 1011 produces 2 matches.
REQ-025 Non-overlap mode: on a match cycle, fill is set to 0 instead of incrementing, so 1011011 produces 1 match.
REQ-026 Idle: an input_valid=0 cycle leaves history and fill unchanged and holds detected at 0.
REQ-027 cfg_load with 1 <= cfg_len <= PAT_W: latch the pattern and length, clear fill to 0, and discard any simultaneous input bit.
REQ-028 cfg_load with cfg_len = 0 or cfg_len > PAT_W: keep the old configuration, still clear fill, discard the input bit, and pulse cfg_err high for the next cycle.
REQ-029 det_count increments by 1 on each detected cycle and saturates at 2^CNT_W-1.
REQ-030 cnt_clr and detected in the same cycle: det_count becomes 1; cnt_clr alone: det_count becomes 0.
REQ-031 Pattern bits above L-1 are ignored in comparison.

Reset
REQ-032 While reset is high: history = 0, fill = 0, pattern = RST_PAT, length = RST_LEN, det_count = 0, detected_q = 0, cfg_err = 0.
REQ-033 While reset is high, detected is forced to 0 and all other inputs are ignored.
REQ-034 Reset asserted mid-match discards the partial match; a pattern spanning the reset is never detected.

Verification
REQ-035 Reset defaults, overlap=1, bits 1,0,1,1,0,1,1 -> detected high on bits 4 and 7; det_count=2; detected_q one cycle after each.
REQ-036 Same stream with overlap=0 -> detected high on bit 4 only; det_count=1.
REQ-037 cfg_load with pattern 8'b1100_0011, len 8, then stream 11000011 -> detected on the 8th bit; cfg_load with cfg_len=9 -> cfg_err pulses once and the 8-bit config is retained.
REQ-038 Bits 1,0,1 then reset for one cycle then bit 1 -> no detection; det_count=0.
REQ-039 CNT_W=2, continuous 1s with pattern len 1 pattern 1 -> det_count saturates at 3; cnt_clr asserted together with a match -> det_count=1.
REQ-040 input_valid gaps inserted between bits of 1011 -> detection still on the final valid bit; detected stays 0 on invalid cycles.
